// File: rtl/const_load_seq_pkg.sv
// Shared types for the constant-load sequencer: opcodes, FSM states and ALU format codes.
package const_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_LOADLIT = 2'b01,
        OP_LCL     = 2'b10,
        OP_LCH     = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10,
        S_WB   = 2'b11
    } state_t;

    localparam logic [1:0] FMT_IDLE  = 2'b00;
    localparam logic [1:0] FMT_PASS  = 2'b01;
    localparam logic [1:0] FMT_MERGE = 2'b11;

endpackage

// File: rtl/const_load_seq_if.sv
// Decode request, register-file and constant-ALU signals of the constant-load sequencer.
// master = sequencer side, slave = decode / register file / ALU side.
interface const_load_seq_if #(
    parameter int unsigned bits_palavra = 16,
    parameter int unsigned REG_AW       = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic [1:0]              req_op;
    logic [REG_AW-1:0]       req_rd;
    logic [bits_palavra-1:0] req_imm;

    logic [REG_AW-1:0]       rf_raddr;
    logic                    rf_re;
    logic [bits_palavra-1:0] rf_rdata;

    logic [bits_palavra-1:0] ula_dado;
    logic [bits_palavra-1:0] ula_constante;
    logic [1:0]              ula_formato;
    logic                    ula_R;
    logic [bits_palavra-1:0] ula_result;

    logic [REG_AW-1:0]       rf_waddr;
    logic [bits_palavra-1:0] rf_wdata;
    logic                    rf_we;
    logic                    done;

    modport master (
        input  req_valid, req_op, req_rd, req_imm, rf_rdata, ula_result,
        output req_ready, rf_raddr, rf_re, ula_dado, ula_constante, ula_formato, ula_R,
               rf_waddr, rf_wdata, rf_we, done
    );

    modport slave (
        output req_valid, req_op, req_rd, req_imm, rf_rdata, ula_result,
        input  req_ready, rf_raddr, rf_re, ula_dado, ula_constante, ula_formato, ula_R,
               rf_waddr, rf_wdata, rf_we, done
    );
endinterface

// File: rtl/const_load_seq.sv
// Multi-cycle sequencer for LOADLIT / LCL / LCH: optional destination read, one ALU cycle,
// then a single-cycle register-file writeback with a matching done pulse.
module const_load_seq
    import const_seq_pkg::*;
#(
    parameter int unsigned bits_palavra = 16,
    parameter int unsigned REG_AW       = 4
) (
    input  logic             clock,
    input  logic             reset,
    const_load_seq_if.master bus
);

    localparam int unsigned BYTE_W = bits_palavra / 2;

    state_t                  state_q;
    state_t                  state_d;
    op_t                     op_q;
    logic [REG_AW-1:0]       rd_q;
    logic [bits_palavra-1:0] imm_q;
    logic [bits_palavra-1:0] dado_q;
    logic [bits_palavra-1:0] res_q;

    logic idle_c;
    logic xfer_c;

    assign idle_c = (state_q == S_IDLE);
    assign xfer_c = idle_c & bus.req_valid;

    // State and datapath registers; request fields are only sampled on a transfer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            rd_q    <= '0;
            imm_q   <= '0;
            dado_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (xfer_c) begin
                        op_q  <= op_t'(bus.req_op);
                        rd_q  <= bus.req_rd;
                        imm_q <= bus.req_imm;
                    end
                end
                S_READ:  dado_q <= bus.rf_rdata;
                S_EXEC:  res_q  <= bus.ula_result;
                default: ;
            endcase
        end
    end

    // Next state: NOP transfers are consumed without leaving IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (xfer_c) begin
                    case (op_t'(bus.req_op))
                        OP_LOADLIT:     state_d = S_EXEC;
                        OP_LCL, OP_LCH: state_d = S_READ;
                        default:        state_d = S_IDLE;
                    endcase
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state; ready is also held low while reset is asserted.
    always_comb begin
        bus.req_ready     = 1'b0;
        bus.rf_raddr      = '0;
        bus.rf_re         = 1'b0;
        bus.ula_dado      = '0;
        bus.ula_constante = '0;
        bus.ula_formato   = FMT_IDLE;
        bus.ula_R         = 1'b0;
        bus.rf_waddr      = '0;
        bus.rf_wdata      = '0;
        bus.rf_we         = 1'b0;
        bus.done          = 1'b0;
        case (state_q)
            S_IDLE: bus.req_ready = reset;
            S_READ: begin
                bus.rf_re    = 1'b1;
                bus.rf_raddr = rd_q;
            end
            S_EXEC: begin
                case (op_q)
                    OP_LOADLIT: begin
                        bus.ula_formato   = FMT_PASS;
                        bus.ula_constante = imm_q;
                    end
                    OP_LCL: begin
                        bus.ula_formato   = FMT_MERGE;
                        bus.ula_constante = {BYTE_W'(0), imm_q[BYTE_W-1:0]};
                        bus.ula_dado      = dado_q;
                    end
                    OP_LCH: begin
                        bus.ula_formato   = FMT_MERGE;
                        bus.ula_R         = 1'b1;
                        bus.ula_constante = {imm_q[BYTE_W-1:0], BYTE_W'(0)};
                        bus.ula_dado      = dado_q;
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = rd_q;
                bus.rf_wdata = res_q;
                bus.done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_const_load_seq.sv
// Bench for const_load_seq: register-file and constant-ALU models, a vector table and
// hand-written sequences for back-to-back, reset abort, NOP and busy-period requests.
module tb_const_load_seq;

    logic clock;
    logic reset;

    const_load_seq_if #(.bits_palavra(16), .REG_AW(4)) bus ();

    const_load_seq #(.bits_palavra(16), .REG_AW(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks;
    int errors;

    // Register-file model: combinational read, write on rf_we or bench preload
    logic [15:0] regs [16];
    logic        pre_we;
    logic [3:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clock) begin
        if (bus.rf_we) regs[bus.rf_waddr] <= bus.rf_wdata;
        else if (pre_we) regs[pre_addr] <= pre_data;
    end
    assign bus.rf_rdata = regs[bus.rf_raddr];

    // Constant-ALU model; holds its last result when formato is 00
    logic [15:0] alu_comb;
    logic [15:0] alu_last;
    always_comb begin
        alu_comb = alu_last;
        if (bus.ula_formato == 2'b01)
            alu_comb = bus.ula_constante;
        else if (bus.ula_formato == 2'b11)
            alu_comb = bus.ula_R ? {bus.ula_constante[15:8], bus.ula_dado[7:0]}
                                 : {bus.ula_dado[15:8], bus.ula_constante[7:0]};
    end
    always @(posedge clock or negedge reset) begin
        if (!reset) alu_last <= 16'h0000;
        else if (bus.ula_formato != 2'b00) alu_last <= alu_comb;
    end
    assign bus.ula_result = alu_comb;

    // Scoreboard counters
    int xfer_cnt;
    int done_cnt;
    int split_cnt;
    initial begin
        xfer_cnt  = 0;
        done_cnt  = 0;
        split_cnt = 0;
    end
    always @(posedge clock) begin
        if (reset && bus.req_valid && bus.req_ready && bus.req_op != 2'b00) xfer_cnt <= xfer_cnt + 1;
        if (bus.rf_we && bus.done) done_cnt <= done_cnt + 1;
        if (bus.rf_we !== bus.done) split_cnt <= split_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        @(negedge clock);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  rd;
        logic [15:0] imm;
        logic [15:0] pre;
        logic [1:0]  fmt;
        logic        r;
        logic [15:0] cst;
        logic [15:0] dado;
        logic [15:0] wdata;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        logic exp_re;
        logic is_exec;
        logic is_wb;
        n = (v.op == 2'b01) ? 2 : 3;
        preload(v.rd, v.pre);
        @(negedge clock);
        chk($sformatf("v%0d idle_ready", idx), 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_rd    = v.rd;
        bus.req_imm   = v.imm;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            bus.req_valid = 1'b0;
            exp_re  = (n == 3) && (k == 1);
            is_exec = (k == n - 1);
            is_wb   = (k == n);
            chk($sformatf("v%0d c%0d ready", idx, k), 64'(bus.req_ready), 64'(0));
            chk($sformatf("v%0d c%0d rf_re", idx, k), 64'(bus.rf_re), 64'(exp_re));
            if (exp_re) chk($sformatf("v%0d raddr", idx), 64'(bus.rf_raddr), 64'(v.rd));
            if (is_exec)
                chk($sformatf("v%0d exec fmt/R/const/dado", idx),
                    {29'd0, bus.ula_formato, bus.ula_R, bus.ula_constante, bus.ula_dado},
                    {29'd0, v.fmt, v.r, v.cst, v.dado});
            else
                chk($sformatf("v%0d c%0d fmt", idx, k), 64'(bus.ula_formato), 64'(0));
            chk($sformatf("v%0d c%0d we/done", idx, k), 64'({bus.rf_we, bus.done}),
                64'({is_wb, is_wb}));
            if (is_wb)
                chk($sformatf("v%0d wb waddr/wdata", idx), 64'({bus.rf_waddr, bus.rf_wdata}),
                    64'({v.rd, v.wdata}));
        end
        @(negedge clock);
        chk($sformatf("v%0d back_idle", idx), 64'({bus.req_ready, bus.rf_we}), 64'(2'b10));
        chk($sformatf("v%0d reg", idx), 64'(regs[v.rd]), 64'(v.wdata));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        pre_we        = 1'b0;
        pre_addr      = 4'd0;
        pre_data      = 16'h0000;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_rd    = 4'd0;
        bus.req_imm   = 16'h0000;

        //              op     rd     imm       pre       fmt    R     const     dado      wdata
        vecs[0] = '{2'b01, 4'd3,  16'hBEEF, 16'h0000, 2'b01, 1'b0, 16'hBEEF, 16'h0000, 16'hBEEF};
        vecs[1] = '{2'b10, 4'd5,  16'h12AB, 16'h3456, 2'b11, 1'b0, 16'h00AB, 16'h3456, 16'h34AB};
        vecs[2] = '{2'b11, 4'd5,  16'hFF12, 16'h3456, 2'b11, 1'b1, 16'h1200, 16'h3456, 16'h1256};
        vecs[3] = '{2'b10, 4'd0,  16'hFFFF, 16'h0000, 2'b11, 1'b0, 16'h00FF, 16'h0000, 16'h00FF};
        vecs[4] = '{2'b11, 4'd15, 16'h0080, 16'hABCD, 2'b11, 1'b1, 16'h8000, 16'hABCD, 16'h80CD};
        vecs[5] = '{2'b01, 4'd15, 16'h0000, 16'h5A5A, 2'b01, 1'b0, 16'h0000, 16'h0000, 16'h0000};

        // Reset state
        #12;
        chk("reset outputs", {1'b0, bus.req_ready, bus.rf_re, bus.rf_we, bus.done, bus.ula_formato,
                              bus.ula_R, bus.ula_constante, bus.ula_dado, bus.rf_wdata},
            64'(0));
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("ready after reset", 64'(bus.req_ready), 64'(1));

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Back-to-back with req_valid held: LOADLIT(r1,0001) then LCL(r1,00CC)
        preload(4'd1, 16'h7777);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_rd    = 4'd1;
        bus.req_imm   = 16'h0001;
        @(negedge clock);
        bus.req_op  = 2'b10;
        bus.req_imm = 16'h00CC;
        chk("b2b exec1", 64'({bus.req_ready, bus.ula_formato, bus.ula_constante}),
            64'({1'b0, 2'b01, 16'h0001}));
        @(negedge clock);
        chk("b2b wb1", 64'({bus.req_ready, bus.rf_we, bus.rf_wdata}), 64'({1'b0, 1'b1, 16'h0001}));
        @(negedge clock);
        chk("b2b accept in idle", 64'({bus.req_ready, bus.rf_we}), 64'(2'b10));
        @(negedge clock);
        bus.req_valid = 1'b0;
        chk("b2b read", 64'({bus.rf_re, bus.rf_raddr, bus.rf_rdata}), 64'({1'b1, 4'd1, 16'h0001}));
        @(negedge clock);
        chk("b2b exec2", 64'({bus.ula_formato, bus.ula_dado, bus.ula_constante}),
            64'({2'b11, 16'h0001, 16'h00CC}));
        @(negedge clock);
        chk("b2b wb2", 64'({bus.rf_we, bus.done, bus.rf_waddr, bus.rf_wdata}),
            64'({2'b11, 4'd1, 16'h00CC}));
        @(negedge clock);
        chk("b2b idle", 64'({bus.req_ready, bus.rf_we}), 64'(2'b10));

        // Reset asserted during EXEC of LCH: write must be dropped
        preload(4'd7, 16'hAAAA);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b11;
        bus.req_rd    = 4'd7;
        bus.req_imm   = 16'h0055;
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        chk("abort exec", 64'({bus.ula_formato, bus.ula_R}), 64'(3'b111));
        #2;
        reset = 1'b0;
        #1;
        chk("abort outputs", {1'b0, bus.req_ready, bus.rf_re, bus.rf_we, bus.done, bus.ula_formato,
                              bus.ula_R, bus.ula_constante, bus.ula_dado, bus.rf_wdata},
            64'(0));
        @(negedge clock);
        chk("abort held", 64'({bus.rf_we, bus.done, bus.req_ready}), 64'(0));
        reset = 1'b1;
        #1;
        chk("abort ready", 64'(bus.req_ready), 64'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("abort idle c%0d", k), 64'({bus.req_ready, bus.rf_we, bus.done}),
                64'(3'b100));
        end
        chk("abort reg kept", 64'(regs[7]), 64'(16'hAAAA));

        // NOP transfer: consumed with no writeback
        preload(4'd9, 16'h0909);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_rd    = 4'd9;
        bus.req_imm   = 16'h1234;
        @(negedge clock);
        bus.req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("nop c%0d", k), 64'({bus.req_ready, bus.rf_re, bus.rf_we, bus.done}),
                64'(4'b1000));
            @(negedge clock);
        end

        // Busy period: req_* churn while not ready must be ignored
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_rd    = 4'd2;
        bus.req_imm   = 16'h1111;
        @(negedge clock);
        bus.req_op  = 2'b11;
        bus.req_rd  = 4'd9;
        bus.req_imm = 16'hFFFF;
        chk("busy exec", 64'({bus.req_ready, bus.ula_constante}), 64'({1'b0, 16'h1111}));
        @(negedge clock);
        bus.req_valid = 1'b0;
        chk("busy wb", 64'({bus.req_ready, bus.rf_we, bus.rf_waddr, bus.rf_wdata}),
            64'({2'b01, 4'd2, 16'h1111}));
        @(negedge clock);
        chk("busy idle", 64'({bus.req_ready, bus.rf_re, bus.rf_we}), 64'(3'b100));
        @(negedge clock);
        chk("busy reg9 kept", 64'(regs[9]), 64'(16'h0909));
        chk("busy reg2", 64'(regs[2]), 64'(16'h1111));

        // Scoreboard: 6 table + 2 back-to-back + 1 aborted + 1 busy transfers
        chk("xfer count", 64'(xfer_cnt), 64'(10));
        chk("done count", 64'(done_cnt), 64'(9));
        chk("we/done split", 64'(split_cnt), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
